addsub_serial: RTL and testbench

- Parametrised, multi-cycle, digit-serial adder/subtractor. Processes DIGIT bits per clock through a two's-complement full-adder slice.
- Subtraction is A + ~B + 1. The final carry produces the unsigned sign/borrow flag.
- Adds an add/sub mode, a start/busy/done handshake, and carry, overflow and zero flags.
- Sits in the ALU datapath as the shared arithmetic unit for wide operands, where area matters more than latency.

---
 rtl/addsub_pkg.sv | 23 ++
 rtl/addsub_serial_if.sv | 34 +++
 rtl/addsub_digit.sv | 36 +++
 rtl/addsub_serial.sv | 121 ++++++++++++
 tb/tb_addsub_serial.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types, opcode constants and sizing helper for addsub_serial
//
// Contents:
//   state_t   : FSM states {IDLE, RUN}
//   OP_ADD    : op encoding for A+B
//   OP_SUB    : op encoding for A-B
//   cnt_width : width of a counter that must hold 0..steps
package addsub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // A single-step configuration (steps=1) still needs a 1-bit counter.
    function automatic int cnt_width(input int steps);
        return (steps < 1) ? 1 : $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// rtl/addsub_serial_if.sv - request/result bundle between a client and addsub_serial
//
// Signals:
//   start, op, a_num, b_num         : request from the client
//   busy, done                      : handshake status from the unit
//   result, carry, sign, ovf, zero  : registered result and flags
// Modports:
//   master : client side (drives the request)
//   slave  : arithmetic unit side (drives status and results)
interface addsub_serial_if #(
    parameter int N = 8
);
    logic         start;
    logic         op;
    logic [N-1:0] a_num;
    logic [N-1:0] b_num;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         carry;
    logic         sign;
    logic         ovf;
    logic         zero;

    modport master (
        output start, op, a_num, b_num,
        input  busy, done, result, carry, sign, ovf, zero
    );

    modport slave (
        input  start, op, a_num, b_num,
        output busy, done, result, carry, sign, ovf, zero
    );
endinterface

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - combinational DIGIT-bit ripple-carry adder slice
//
// Ports:
//   a, b     : DIGIT-bit operand digits
//   cin      : carry into bit 0
//   sum      : DIGIT-bit sum digit
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (for signed overflow on the last digit)
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        c        = cin;
        c_msb_in = cin;
        sum      = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb_in = c;
            end
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial two's-complement adder/subtractor, DIGIT bits per clock
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : addsub_serial_if.slave (start/op/a_num/b_num in; busy/done/result/flags out)
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int N     = 8,
    parameter int DIGIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    addsub_serial_if.slave  bus
);

    localparam int STEPS = N / DIGIT;
    localparam int CW    = cnt_width(STEPS);

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   res_sr;
    logic [N-1:0]   res_next;
    logic           cin_reg;
    logic           op_reg;
    logic [CW-1:0]  step_cnt;
    logic           last_step;

    logic [DIGIT-1:0] sum;
    logic             cout;
    logic             c_msb_in;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a        (a_sr[DIGIT-1:0]),
        .b        (b_sr[DIGIT-1:0]),
        .cin      (cin_reg),
        .sum      (sum),
        .cout     (cout),
        .c_msb_in (c_msb_in)
    );

    // New sum digits enter at the MSB end; after STEPS shifts the first digit sits at bit 0.
    generate
        if (STEPS > 1) begin : g_shift
            assign res_next = {sum, res_sr[N-1:DIGIT]};
        end else begin : g_single
            assign res_next = sum;
        end
    endgenerate

    assign last_step = (state == RUN) && (step_cnt == CW'(STEPS - 1));
    assign bus.busy  = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN:  if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cin_reg    <= 1'b0;
            op_reg     <= 1'b0;
            step_cnt   <= '0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.carry  <= 1'b0;
            bus.sign   <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.zero   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr     <= bus.a_num;
                        // Subtract as A + ~B + 1: invert B here, seed the +1 as carry-in.
                        b_sr     <= (bus.op == OP_SUB) ? ~bus.b_num : bus.b_num;
                        cin_reg  <= bus.op;
                        op_reg   <= bus.op;
                        step_cnt <= '0;
                    end
                end
                RUN: begin
                    a_sr     <= a_sr >> DIGIT;
                    b_sr     <= b_sr >> DIGIT;
                    res_sr   <= res_next;
                    cin_reg  <= cout;
                    step_cnt <= step_cnt + CW'(1);
                    if (last_step) begin
                        bus.result <= res_next;
                        bus.carry  <= cout;
                        bus.sign   <= (op_reg == OP_SUB) & ~cout;
                        bus.ovf    <= c_msb_in ^ cout;
                        bus.zero   <= (res_next == '0);
                        bus.done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - directed self-checking bench for addsub_serial at DIGIT = 1, 4 and 8
module tb_addsub_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    addsub_serial_if #(.N(8)) bus1 ();
    addsub_serial_if #(.N(8)) bus4 ();
    addsub_serial_if #(.N(8)) bus8 ();

    addsub_serial #(.N(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    addsub_serial #(.N(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    addsub_serial #(.N(8), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] res_of(input int u);
        case (u)
            1:       return bus1.result;
            4:       return bus4.result;
            default: return bus8.result;
        endcase
    endfunction

    // {carry, sign, ovf, zero}
    function automatic logic [3:0] flags_of(input int u);
        case (u)
            1:       return {bus1.carry, bus1.sign, bus1.ovf, bus1.zero};
            4:       return {bus4.carry, bus4.sign, bus4.ovf, bus4.zero};
            default: return {bus8.carry, bus8.sign, bus8.ovf, bus8.zero};
        endcase
    endfunction

    function automatic logic busy_of(input int u);
        case (u)
            1:       return bus1.busy;
            4:       return bus4.busy;
            default: return bus8.busy;
        endcase
    endfunction

    function automatic logic done_of(input int u);
        case (u)
            1:       return bus1.done;
            4:       return bus4.done;
            default: return bus8.done;
        endcase
    endfunction

    task automatic drive(input int u, input logic s, input logic o, input logic [7:0] a, input logic [7:0] b);
        case (u)
            1: begin bus1.start = s; bus1.op = o; bus1.a_num = a; bus1.b_num = b; end
            4: begin bus4.start = s; bus4.op = o; bus4.a_num = a; bus4.b_num = b; end
            default: begin bus8.start = s; bus8.op = o; bus8.a_num = a; bus8.b_num = b; end
        endcase
    endtask

    // Called 2 time units after a rising edge; start is sampled on the next edge (E0).
    task automatic start_op(input int u, input logic o, input logic [7:0] a, input logic [7:0] b);
        drive(u, 1'b1, o, a, b);
        @(posedge clk); #2;
        drive(u, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Counts edges after E0 until done is seen; busy_cnt includes the sample right after E0.
    task automatic wait_done(input int u, output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = busy_of(u) ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #2;
            cyc++;
            if (busy_of(u)) busy_cnt++;
            if (done_of(u)) break;
        end
        if (!done_of(u)) begin
            check("done_timeout", 32'(cyc), 32'hFFFF_FFFF);
        end
    endtask

    typedef struct {
        string      tag;
        int         unit;
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flags;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int cyc;
        int bcnt;
        int tot;
        int dcnt;

        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(4, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(8, 1'b0, 1'b0, 8'h00, 8'h00);

        //        tag          unit op    a      b      result  {c,s,v,z} latency
        vecs.push_back('{"sub_5_3",   1, 1'b1, 8'h05, 8'h03, 8'h02, 4'b1000, 8});
        vecs.push_back('{"sub_3_5",   1, 1'b1, 8'h03, 8'h05, 8'hFE, 4'b0100, 8});
        vecs.push_back('{"sub_80_01", 1, 1'b1, 8'h80, 8'h01, 8'h7F, 4'b1010, 8});
        vecs.push_back('{"add_7f_01", 4, 1'b0, 8'h7F, 8'h01, 8'h80, 4'b0010, 2});
        vecs.push_back('{"add_ff_01", 4, 1'b0, 8'hFF, 8'h01, 8'h00, 4'b1001, 2});
        vecs.push_back('{"sub_5a_5a", 8, 1'b1, 8'h5A, 8'h5A, 8'h00, 4'b1001, 1});
        vecs.push_back('{"add_c8_64", 1, 1'b0, 8'hC8, 8'h64, 8'h2C, 4'b1000, 8});

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        check("reset_busy1",  32'(busy_of(1)),  32'd0);
        check("reset_res1",   32'(res_of(1)),   32'd0);
        check("reset_flags4", 32'(flags_of(4)), 32'd0);
        check("reset_done8",  32'(done_of(8)),  32'd0);

        foreach (vecs[i]) begin
            start_op(vecs[i].unit, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].unit, cyc, bcnt);
            check({vecs[i].tag, "_lat"},   32'(cyc),                    32'(vecs[i].lat));
            check({vecs[i].tag, "_busy"},  32'(bcnt),                   32'(vecs[i].lat));
            check({vecs[i].tag, "_res"},   32'(res_of(vecs[i].unit)),   32'(vecs[i].res));
            check({vecs[i].tag, "_flags"}, 32'(flags_of(vecs[i].unit)), 32'(vecs[i].flags));
            @(posedge clk); #2;
            check({vecs[i].tag, "_done1"}, 32'(done_of(vecs[i].unit)),  32'd0);
            check({vecs[i].tag, "_idle"},  32'(busy_of(vecs[i].unit)),  32'd0);
        end

        // Outputs hold while idle.
        repeat (3) @(posedge clk);
        #2;
        check("hold_res", 32'(res_of(1)),   32'h2C);
        check("hold_flg", 32'(flags_of(1)), 32'b1000);

        // Start during RUN is ignored; start in the done cycle is accepted.
        start_op(1, 1'b0, 8'h10, 8'h20);
        repeat (2) begin @(posedge clk); #2; end
        drive(1, 1'b1, 1'b1, 8'hFF, 8'hFF);
        @(posedge clk); #2;
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_done(1, cyc, bcnt);
        tot = 3 + cyc;
        check("ign_lat",   32'(tot),         32'd8);
        check("ign_res",   32'(res_of(1)),   32'h30);
        check("ign_flags", 32'(flags_of(1)), 32'b0000);
        start_op(1, 1'b0, 8'h01, 8'h02);
        wait_done(1, cyc, bcnt);
        check("b2b_lat", 32'(cyc),       32'd8);
        check("b2b_res", 32'(res_of(1)), 32'h03);

        // Reset at cycle 4 of RUN abandons the operation.
        start_op(1, 1'b0, 8'h11, 8'h22);
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("rst_busy",  32'(busy_of(1)),  32'd0);
        check("rst_done",  32'(done_of(1)),  32'd0);
        check("rst_res",   32'(res_of(1)),   32'd0);
        check("rst_flags", 32'(flags_of(1)), 32'd0);
        dcnt = 0;
        repeat (10) begin
            @(posedge clk); #2;
            if (done_of(1)) dcnt++;
        end
        check("rst_no_done", 32'(dcnt), 32'd0);
        start_op(1, 1'b0, 8'h11, 8'h22);
        wait_done(1, cyc, bcnt);
        check("post_rst_lat", 32'(cyc),       32'd8);
        check("post_rst_res", 32'(res_of(1)), 32'h33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
